// File: rtl/usrt_pkg.sv
// Shared USRT definitions: parity mode codes and framer state encoding.
package usrt_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/usrt_parity_gen.sv
// Combinational parity bit for a data word; modes other than odd/even yield 0.
module usrt_parity_gen
    import usrt_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    output logic              parity_c
);

    always_comb begin
        parity_c = 1'b0;
        case (mode)
            PAR_ODD:  parity_c = ~^data;
            PAR_EVEN: parity_c = ^data;
            default:  parity_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/usrt_tx_serializer.sv
// USRT transmit framer: start bit, LSB-first data, optional parity, 1 or 2 stop bits,
// one serial bit per i_Bit_en strobe.
module usrt_tx_serializer
    import usrt_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              i_Pclk,
    input  logic              i_Rst_n,
    input  logic              i_Bit_en,
    input  logic              i_Valid,
    output logic              o_Ready,
    input  logic [DATA_W-1:0] i_Data,
    input  logic [1:0]        i_Parity,
    input  logic              i_Stop2,
    output logic              o_Tx,
    output logic              o_Busy,
    output logic              o_Done
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic                par_en_q, par_en_d;
    logic                par_bit_q, par_bit_d;
    logic                stop2_q, stop2_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
    logic                par_c;

    // Parity is taken from the incoming word so it is frozen at accept time.
    usrt_parity_gen #(.DATA_W(DATA_W)) u_parity (
        .data     (i_Data),
        .mode     (i_Parity),
        .parity_c (par_c)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (i_Valid) begin
                    shreg_d   = i_Data;
                    par_en_d  = (i_Parity == PAR_ODD) || (i_Parity == PAR_EVEN);
                    par_bit_d = par_c;
                    stop2_d   = i_Stop2;
                    state_d   = S_START;
                    tx_d      = 1'b0;
                end
            end
            S_START: begin
                if (i_Bit_en) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (i_Bit_en) begin
                    if (idx_q == CNT_W'(DATA_W - 1)) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = S_STOP;
                            stop_cnt_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + CNT_W'(1);
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (i_Bit_en) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (i_Bit_en) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign o_Ready = (state_q == S_IDLE);
    assign o_Busy  = (state_q != S_IDLE);
    assign o_Tx    = tx_q;
    assign o_Done  = done_q;

endmodule

// File: tb/tb_usrt_tx_serializer.sv
// Directed bench for usrt_tx_serializer: 8-bit and 5-bit builds side by side.
module tb_usrt_tx_serializer;

    logic       clk;
    logic       rst_n;
    logic       bit_en;
    logic       valid8, valid5;
    logic [7:0] data8;
    logic [4:0] data5;
    logic [1:0] par;
    logic       stop2;
    logic       ready8, tx8, busy8, done8;
    logic       ready5, tx5, busy5, done5;
    logic       sel;
    int         errors;
    int         checks;

    usrt_tx_serializer #(.DATA_W(8)) dut8 (
        .i_Pclk   (clk),
        .i_Rst_n  (rst_n),
        .i_Bit_en (bit_en),
        .i_Valid  (valid8),
        .o_Ready  (ready8),
        .i_Data   (data8),
        .i_Parity (par),
        .i_Stop2  (stop2),
        .o_Tx     (tx8),
        .o_Busy   (busy8),
        .o_Done   (done8)
    );

    usrt_tx_serializer #(.DATA_W(5)) dut5 (
        .i_Pclk   (clk),
        .i_Rst_n  (rst_n),
        .i_Bit_en (bit_en),
        .i_Valid  (valid5),
        .o_Ready  (ready5),
        .i_Data   (data5),
        .i_Parity (par),
        .i_Stop2  (stop2),
        .o_Tx     (tx5),
        .o_Busy   (busy5),
        .o_Done   (done5)
    );

    wire tx_m    = sel ? tx5    : tx8;
    wire busy_m  = sel ? busy5  : busy8;
    wire done_m  = sel ? done5  : done8;
    wire ready_m = sel ? ready5 : ready8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sends one frame with i_Bit_en every 'period' clocks and checks every clock of it.
    task automatic run_frame(input logic s, input logic [7:0] d, input logic [1:0] p,
                             input logic st2, input int period, input logic [0:15] exp,
                             input int nbits, input string name);
        int done_cnt;
        done_cnt = 0;
        sel = s;
        @(negedge clk);
        checks++;
        if (ready_m !== 1'b1) begin
            errors++;
            $display("FAIL %s ready before accept: got %b want 1", name, ready_m);
        end
        if (s) begin valid5 = 1'b1; data5 = d[4:0]; end
        else   begin valid8 = 1'b1; data8 = d; end
        par = p; stop2 = st2; bit_en = 1'b1;
        @(negedge clk);
        valid8 = 1'b0; valid5 = 1'b0;
        data8 = ~data8; data5 = ~data5; par = ~p; stop2 = ~st2;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < period; c++) begin
                checks++;
                if (tx_m !== exp[b] || busy_m !== 1'b1) begin
                    errors++;
                    $display("FAIL %s bit %0d clk %0d: tx=%b busy=%b want tx=%b busy=1",
                             name, b, c, tx_m, busy_m, exp[b]);
                end
                if (done_m === 1'b1) done_cnt++;
                bit_en = (c == period - 1);
                @(negedge clk);
            end
        end
        bit_en = 1'b0;
        checks++;
        if (done_m !== 1'b1 || tx_m !== 1'b1 || busy_m !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL %s end: done=%b tx=%b busy=%b early_done=%0d want 1,1,0,0",
                     name, done_m, tx_m, busy_m, done_cnt);
        end
        @(negedge clk);
        checks++;
        if (done_m !== 1'b0 || tx_m !== 1'b1) begin
            errors++;
            $display("FAIL %s done width: done=%b tx=%b want 0,1", name, done_m, tx_m);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        checks++;
        if (tx8 !== 1'b1 || ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 ||
            tx5 !== 1'b1 || ready5 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: tx=%b ready=%b busy=%b done=%b tx5=%b ready5=%b",
                     tx8, ready8, busy8, done8, tx5, ready5);
        end
        @(negedge clk);
        valid8 = 1'b1; data8 = 8'h00; par = 2'b01; stop2 = 1'b0;
        @(negedge clk);
        valid8 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bit_en = (i % 2 == 1);
            @(negedge clk);
        end
        bit_en = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || tx8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_middata_pre: busy=%b tx=%b want 1,0", busy8, tx8);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (tx8 !== 1'b1 || busy8 !== 1'b0 || ready8 !== 1'b1 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: tx=%b busy=%b ready=%b done=%b want 1,0,1,0",
                     tx8, busy8, ready8, done8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(1'b0, 8'h03, 2'b01, 1'b0, 4, 16'b0110_0000_0110_0000, 11, "post_reset");
    endtask

    task automatic test_parity();
        run_frame(1'b0, 8'h03, 2'b01, 1'b0, 4, 16'b0110_0000_0110_0000, 11, "odd_03");
        run_frame(1'b0, 8'h07, 2'b10, 1'b0, 4, 16'b0111_0000_0110_0000, 11, "even_07");
        run_frame(1'b0, 8'h03, 2'b10, 1'b0, 4, 16'b0110_0000_0010_0000, 11, "even_03");
    endtask

    task automatic test_no_parity_stop2();
        run_frame(1'b0, 8'hA5, 2'b00, 1'b1, 2, 16'b0101_0010_1110_0000, 11, "none_stop2");
        run_frame(1'b0, 8'hA5, 2'b11, 1'b1, 3, 16'b0101_0010_1110_0000, 11, "mode11_stop2");
    endtask

    task automatic test_width5();
        run_frame(1'b1, 8'h1F, 2'b01, 1'b0, 2, 16'b0111_1101_0000_0000, 8, "w5_odd_1f");
    endtask

    task automatic test_back_to_back();
        logic [0:15] e1;
        logic [0:15] e2;
        e1 = 16'b0110_0000_0110_0000;
        e2 = 16'b0101_0010_1100_0000;
        sel = 1'b0;
        @(negedge clk);
        valid8 = 1'b1; data8 = 8'h03; par = 2'b01; stop2 = 1'b0; bit_en = 1'b1;
        @(negedge clk);
        data8 = 8'hA5; par = 2'b00;
        for (int b = 0; b < 11; b++) begin
            checks++;
            if (tx8 !== e1[b] || busy8 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_f1 bit %0d: tx=%b busy=%b want tx=%b busy=1",
                         b, tx8, busy8, e1[b]);
            end
            @(negedge clk);
        end
        checks++;
        if (tx8 !== 1'b1 || done8 !== 1'b1 || ready8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: tx=%b done=%b ready=%b want 1,1,1", tx8, done8, ready8);
        end
        @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (tx8 !== e2[b] || busy8 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_f2 bit %0d: tx=%b busy=%b want tx=%b busy=1",
                         b, tx8, busy8, e2[b]);
            end
            @(negedge clk);
        end
        valid8 = 1'b0;
        checks++;
        if (done8 !== 1'b1 || ready8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_f2_done: done=%b ready=%b want 1,1", done8, ready8);
        end
        @(negedge clk);
        bit_en = 1'b0;
        checks++;
        if (busy8 !== 1'b0 || tx8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b tx=%b want 0,1", busy8, tx8);
        end
    endtask

    initial begin
        errors = 0; checks = 0; sel = 1'b0;
        rst_n = 1'b0; bit_en = 1'b0; valid8 = 1'b0; valid5 = 1'b0;
        data8 = '0; data5 = '0; par = 2'b00; stop2 = 1'b0;
        #23 rst_n = 1'b1;
        test_reset();
        test_parity();
        test_no_parity_stop2();
        test_width5();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usrt_tx_serializer.md
Name: usrt_tx_serializer

Overview:
Parametrised USRT transmit framer/serializer: accepts a DATA_W-bit word over a valid/ready handshake and frames it as start bit, LSB-first data, optional parity and 1 or 2 stop bits. Frames are shifted onto a single serial line, one bit per i_Bit_en pulse. It generalises the fixed 8-bit, parity-only framer: data width is a parameter, a "none" parity mode and selectable stop-bit count are added, and serialization plus flow control are included. It sits between the transmit data source (FIFO/host) and the USRT line driver.

Parameters:
DATA_W, 8, data bits per frame (5..16)
CNT_W, $clog2(DATA_W+1), width of the internal bit counter (derived; do not override)

Ports:
i_Pclk  in  1  system clock; all logic on rising edge
i_Rst_n  in  1  asynchronous active-low reset
i_Bit_en  in  1  bit-rate strobe; one serial bit advances per high cycle
i_Valid  in  1  source has a word on i_Data
o_Ready  out  1  block can accept a word (IDLE only)
i_Data  in  DATA_W  word to send
i_Parity  in  2  00 none, 01 odd, 10 even, 11 treated as none
i_Stop2  in  1  1 = two stop bits, 0 = one stop bit
o_Tx  out  1  serial line; idle/mark level = 1
o_Busy  out  1  frame in progress (state != IDLE)
o_Done  out  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (async, i_Rst_n=0): state IDLE, o_Tx=1, o_Ready=1, o_Busy=0, o_Done=0, shift register and counters cleared. Applies immediately, including mid-frame. The partial frame is abandoned and never resumed.
- States: IDLE -> START -> DATA -> (PARITY if mode 01/10) -> STOP -> IDLE.
- Accept: on a rising edge with i_Valid=1 and o_Ready=1, the block latches i_Data, i_Parity and i_Stop2 and moves to START. o_Tx=0 from the next edge.
  - Later input changes do not affect the frame in flight.
- o_Ready = (state==IDLE). i_Valid while busy is ignored; the source must hold i_Valid until accepted.
- Bit advance: in every non-IDLE state, a cycle with i_Bit_en=1 ends the current bit. With i_Bit_en=0, o_Tx holds.
- START: o_Tx=0. On i_Bit_en, go to DATA with bit index 0.
- DATA: o_Tx = data[index], LSB first. On i_Bit_en, index increments. After index DATA_W-1, go to PARITY if the parity mode is 01/10, else to STOP.
- PARITY: odd mode drives ~^data (total ones incl. parity is odd); even mode drives ^data. On i_Bit_en, go to STOP.
- STOP: o_Tx=1 for 1 or 2 bit periods per the latched i_Stop2. On the final i_Bit_en, return to IDLE and pulse o_Done for that edge's following cycle only.
- Back-to-back frames: the next accept can occur in the first IDLE cycle. This gives at least one clock of idle mark between the last stop bit and the next start bit.
- Frame length in bit periods: 1 + DATA_W + (parity?1:0) + (stop2?2:1). For 8 data bits, parity and 1 stop bit this is 11.
- i_Bit_en high on the accept edge does not advance. The start bit always lasts until the first i_Bit_en after the accept edge.
- All outputs are registered except o_Ready and o_Busy, which are decoded from the state register.

Decomposition:
- Shared package usrt_pkg holds:
  - parity mode constants PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10
  - state encoding localparams S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
- One natural sub-module: usrt_parity_gen (parametrised DATA_W, combinational). Inputs: data and mode. Output: parity bit. It is reused by the future receive checker.

Test Plan:
- Reset: assert i_Rst_n=0 mid-DATA of a frame -> o_Tx=1, o_Busy=0, o_Ready=1 immediately. After release, the next frame sends cleanly from its start bit.
- DATA_W=8, i_Data=8'h03, i_Parity=01, i_Stop2=0, i_Bit_en every 4th clock -> o_Tx bit sequence 0,1,1,0,0,0,0,0,0,1,1 (11 bits, parity=1), each bit held 4 clocks, o_Done one pulse.
- i_Data=8'h07, i_Parity=10 -> sequence 0,1,1,1,0,0,0,0,0,1,1 (parity=1). i_Data=8'h03, i_Parity=10 -> parity bit 0.
- i_Parity=00 and 11, i_Stop2=1, i_Data=8'hA5 -> 0,1,0,1,0,0,1,0,1,1,1 (no parity bit, two stop bits), 11 bit periods.
- Back-to-back with i_Valid held high and i_Bit_en=1 constant:
  - frame 2 is accepted on the first IDLE cycle
  - exactly one idle clock with o_Tx=1 precedes the next start bit
  - changing i_Data/i_Parity mid-frame does not alter frame 1
- DATA_W=5 build, i_Data=5'h1F, odd parity -> 0,1,1,1,1,1,0,1 (8 bit periods), o_Done pulse width exactly 1 clock.
